// File: rtl/mem_arb_defs.sv
// Shared definitions for the memory arbiter: FSM state encodings, bus owner codes
// and the width of the fairness counter.
package mem_arb_defs;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INST_WAIT = 2'd1,
        DATA_WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam int CNT_W = 3;

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational grant selection: honours a pending lock, otherwise data wins, unless
// MEM_ARB_FAIR_EN is defined and inst has waited through STARVE_MAX data grants.
module mem_arb_sel
    import mem_arb_defs::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic             inst_req,
    input  logic             data_req,
    input  logic             lock_valid,
    input  owner_t           lock_owner,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant_valid,
    output owner_t           grant_owner
);

    logic lock_live;

    // A lock only binds while the locked master is still asking for the bus.
    assign lock_live = lock_valid && ((lock_owner == OWN_DATA) ? data_req : inst_req);

`ifndef MEM_ARB_FAIR_EN
    logic unused_cfg;
    assign unused_cfg = ^{starve_cnt, CNT_W'(STARVE_MAX)};
`endif

    always_comb begin
        grant_valid = inst_req || data_req;
        grant_owner = OWN_INST;
        if (lock_live) begin
            grant_owner = lock_owner;
        end else if (data_req) begin
            grant_owner = OWN_DATA;
`ifdef MEM_ARB_FAIR_EN
            if (inst_req && (starve_cnt == CNT_W'(STARVE_MAX))) begin
                grant_owner = OWN_INST;
            end
`endif
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (fetch / load-store) arbiter onto one sram-like bus, one transaction
// outstanding. Optional inst starvation guard enabled by defining MEM_ARB_FAIR_EN.
module mem_arbiter
    import mem_arb_defs::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    arb_state_t       state_q, state_d;
    logic             lock_valid_q, lock_valid_d;
    owner_t           lock_owner_q, lock_owner_d;
    logic [CNT_W-1:0] starve_cnt;
    logic             grant_valid;
    owner_t           grant_owner;
    logic             accept;

    mem_arb_sel #(
        .STARVE_MAX (STARVE_MAX)
    ) u_sel (
        .inst_req    (inst_req),
        .data_req    (data_req),
        .lock_valid  (lock_valid_q),
        .lock_owner  (lock_owner_q),
        .starve_cnt  (starve_cnt),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign accept = bus_req && bus_addr_ok;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            lock_valid_q <= 1'b0;
            lock_owner_q <= OWN_INST;
        end else begin
            state_q      <= state_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = (grant_owner == OWN_DATA) ? DATA_WAIT : INST_WAIT;
            INST_WAIT,
            DATA_WAIT: if (bus_data_ok) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Refused requests pin the grant so a later higher-priority request cannot cut in.
    always_comb begin
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        if (state_q == IDLE) begin
            if (!grant_valid || bus_addr_ok) begin
                lock_valid_d = 1'b0;
            end else begin
                lock_valid_d = 1'b1;
                lock_owner_d = grant_owner;
            end
        end
    end

`ifdef MEM_ARB_FAIR_EN
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) starve_cnt_q <= '0;
        else         starve_cnt_q <= starve_cnt_d;
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!inst_req) begin
            starve_cnt_d = '0;
        end else if (accept) begin
            if (grant_owner == OWN_INST)                 starve_cnt_d = '0;
            else if (starve_cnt_q != {CNT_W{1'b1}})      starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    assign starve_cnt = starve_cnt_q;
`else
    assign starve_cnt = '0;
`endif

    // Outputs are forced low while reset is held, even though most paths are combinational.
    always_comb begin
        bus_req      = 1'b0;
        bus_wr       = 1'b0;
        bus_size     = 2'b00;
        bus_addr     = 32'h0;
        bus_wdata    = 32'h0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        data_rdata   = 32'h0;
        if (resetn) begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        bus_req = 1'b1;
                        if (grant_owner == OWN_DATA) begin
                            bus_wr       = data_wr;
                            bus_size     = data_size;
                            bus_addr     = data_addr;
                            bus_wdata    = data_wdata;
                            data_addr_ok = bus_addr_ok;
                        end else begin
                            bus_wr       = inst_wr;
                            bus_size     = inst_size;
                            bus_addr     = inst_addr;
                            bus_wdata    = inst_wdata;
                            inst_addr_ok = bus_addr_ok;
                        end
                    end
                end
                INST_WAIT: begin
                    inst_data_ok = bus_data_ok;
                    inst_rdata   = bus_data_ok ? bus_rdata : 32'h0;
                end
                DATA_WAIT: begin
                    data_data_ok = bus_data_ok;
                    data_rdata   = bus_data_ok ? bus_rdata : 32'h0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the fairness scenario expects an
// inst grant after four data grants only when MEM_ARB_FAIR_EN is defined.
module tb_mem_arbiter;

`ifdef MEM_ARB_FAIR_EN
    localparam int FAIR_LIMIT = 4;
`else
    localparam int FAIR_LIMIT = 1000;
`endif

    logic        clk;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(
        .STARVE_MAX (4)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_size     (bus_size),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Moves to just after the next rising edge, drives one cycle of inputs, lets them settle.
    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                 input logic dreq, input logic dwr, input logic [1:0] dsize,
                                 input logic [31:0] daddr, input logic [31:0] dwdata,
                                 input logic aok, input logic dok, input logic [31:0] rdata);
        @(posedge clk);
        #1;
        inst_req    = ireq;
        inst_addr   = iaddr;
        data_req    = dreq;
        data_wr     = dwr;
        data_size   = dsize;
        data_addr   = daddr;
        data_wdata  = dwdata;
        bus_addr_ok = aok;
        bus_data_ok = dok;
        bus_rdata   = rdata;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        resetn     = 1'b0;
        inst_wr    = 1'b0;
        inst_size  = 2'd2;
        inst_wdata = 32'h0;
        #1;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
        data_addr = 32'h8000_0000; data_wdata = 32'h1111_1111;
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        #1;
        checkOutput("rst_bus_req",  {31'h0, bus_req},      32'h0);
        checkOutput("rst_bus_addr", bus_addr,              32'h0);
        checkOutput("rst_iaok",     {31'h0, inst_addr_ok}, 32'h0);
        checkOutput("rst_daok",     {31'h0, data_addr_ok}, 32'h0);
        checkOutput("rst_ddok",     {31'h0, data_data_ok}, 32'h0);
        checkOutput("rst_irdata",   inst_rdata,            32'h0);

        idleCycle();
        resetn = 1'b1;
        idleCycle();

        // Inst-only fetch
        applyStimulus(1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("fetch_bus_req",  {31'h0, bus_req},      32'h1);
        checkOutput("fetch_bus_addr", bus_addr,              32'hBFC0_0000);
        checkOutput("fetch_iaok",     {31'h0, inst_addr_ok}, 32'h1);
        checkOutput("fetch_daok",     {31'h0, data_addr_ok}, 32'h0);
        idleCycle();
        checkOutput("fetch_wait_req", {31'h0, bus_req},      32'h0);
        checkOutput("fetch_wait_dok", {31'h0, inst_data_ok}, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h3C1D_0000);
        checkOutput("fetch_idok",   {31'h0, inst_data_ok}, 32'h1);
        checkOutput("fetch_irdata", inst_rdata,            32'h3C1D_0000);
        checkOutput("fetch_ddok",   {31'h0, data_data_ok}, 32'h0);
        checkOutput("fetch_drdata", data_rdata,            32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h5555_5555);
        checkOutput("stray_idok",   {31'h0, inst_data_ok}, 32'h0);
        checkOutput("stray_irdata", inst_rdata,            32'h0);

        // Contention: data first, inst right after data completes
        applyStimulus(1'b1, 32'hBFC0_0004, 1'b1, 1'b0, 2'd2, 32'h8000_1000, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("cont_bus_addr", bus_addr,              32'h8000_1000);
        checkOutput("cont_daok",     {31'h0, data_addr_ok}, 32'h1);
        checkOutput("cont_iaok",     {31'h0, inst_addr_ok}, 32'h0);
        checkOutput("cont_bus_wr",   {31'h0, bus_wr},       32'h0);
        applyStimulus(1'b1, 32'hBFC0_0004, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h1234_5678);
        checkOutput("cont_ddok",     {31'h0, data_data_ok}, 32'h1);
        checkOutput("cont_drdata",   data_rdata,            32'h1234_5678);
        checkOutput("cont_wait_iaok", {31'h0, inst_addr_ok}, 32'h0);
        checkOutput("cont_wait_req", {31'h0, bus_req},      32'h0);
        applyStimulus(1'b1, 32'hBFC0_0004, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("cont_inst_iaok", {31'h0, inst_addr_ok}, 32'h1);
        checkOutput("cont_inst_addr", bus_addr,              32'hBFC0_0004);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hAAAA_5555);
        checkOutput("cont_inst_idok", {31'h0, inst_data_ok}, 32'h1);
        checkOutput("cont_inst_rd",   inst_rdata,            32'hAAAA_5555);
        idleCycle();

        // Lock: refused inst request must not be preempted by data
        applyStimulus(1'b1, 32'hBFC0_0010, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("lock_c1_addr", bus_addr,              32'hBFC0_0010);
        checkOutput("lock_c1_iaok", {31'h0, inst_addr_ok}, 32'h0);
        for (int c = 2; c <= 3; c++) begin
            applyStimulus(1'b1, 32'hBFC0_0010, 1'b1, 1'b0, 2'd2, 32'h8000_2000, 32'h0, 1'b0, 1'b0, 32'h0);
            checkOutput($sformatf("lock_c%0d_addr", c), bus_addr, 32'hBFC0_0010);
            checkOutput($sformatf("lock_c%0d_daok", c), {31'h0, data_addr_ok}, 32'h0);
        end
        applyStimulus(1'b1, 32'hBFC0_0010, 1'b1, 1'b0, 2'd2, 32'h8000_2000, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("lock_acc_addr", bus_addr,              32'hBFC0_0010);
        checkOutput("lock_acc_iaok", {31'h0, inst_addr_ok}, 32'h1);
        checkOutput("lock_acc_daok", {31'h0, data_addr_ok}, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 32'h8000_2000, 32'h0, 1'b1, 1'b1, 32'h0BAD_F00D);
        checkOutput("lock_idok",      {31'h0, inst_data_ok}, 32'h1);
        checkOutput("lock_wait_daok", {31'h0, data_addr_ok}, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 32'h8000_2000, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("lock_data_daok", {31'h0, data_addr_ok}, 32'h1);
        checkOutput("lock_data_addr", bus_addr,              32'h8000_2000);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
        checkOutput("lock_data_ddok", {31'h0, data_data_ok}, 32'h1);
        idleCycle();

        // Store
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 2'd2, 32'h8000_3000, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
        checkOutput("st_bus_wr",    {31'h0, bus_wr},       32'h1);
        checkOutput("st_bus_wdata", bus_wdata,             32'hDEAD_BEEF);
        checkOutput("st_bus_size",  {30'h0, bus_size},     32'h2);
        checkOutput("st_daok",      {31'h0, data_addr_ok}, 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("st_wait_ddok", {31'h0, data_data_ok}, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
        checkOutput("st_ddok",      {31'h0, data_data_ok}, 32'h1);
        idleCycle();

        // Reset in the middle of a data transaction
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 32'h8000_4000, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("rmid_daok", {31'h0, data_addr_ok}, 32'h1);
        idleCycle();
        resetn = 1'b0;
        bus_data_ok = 1'b1;
        #1;
        checkOutput("rmid_held_ddok", {31'h0, data_data_ok}, 32'h0);
        idleCycle();
        resetn = 1'b1;
        applyStimulus(1'b1, 32'hBFC0_0020, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h7777_7777);
        checkOutput("rmid_ddok",   {31'h0, data_data_ok}, 32'h0);
        checkOutput("rmid_drdata", data_rdata,            32'h0);
        checkOutput("rmid_iaok",   {31'h0, inst_addr_ok}, 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
        checkOutput("rmid_idok",   {31'h0, inst_data_ok}, 32'h1);
        idleCycle();

        // Sustained contention: inst wins the fifth grant only with fairness enabled
        for (int g = 0; g < 5; g++) begin
            applyStimulus(1'b1, 32'hBFC0_0040, 1'b1, 1'b0, 2'd2, 32'h8000_5000, 32'h0, 1'b1, 1'b0, 32'h0);
            checkOutput($sformatf("fair_g%0d_daok", g), {31'h0, data_addr_ok}, (g < FAIR_LIMIT) ? 32'h1 : 32'h0);
            checkOutput($sformatf("fair_g%0d_iaok", g), {31'h0, inst_addr_ok}, (g < FAIR_LIMIT) ? 32'h0 : 32'h1);
            applyStimulus(1'b1, 32'hBFC0_0040, 1'b1, 1'b0, 2'd2, 32'h8000_5000, 32'h0, 1'b0, 1'b1, 32'h0);
            checkOutput($sformatf("fair_g%0d_ddok", g), {31'h0, data_data_ok}, (g < FAIR_LIMIT) ? 32'h1 : 32'h0);
        end
        idleCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
